muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit. It is the sequential companion to the single-cycle ALU:
//  it executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over several cycles.

---
 rtl/rv_pkg.sv | 22 ++
 rtl/muldiv_unit_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32M types for the multiply/divide unit: funct3 operation codes and FSM states.
package rv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_step.sv
// One combinational iteration: BITS_PER_CYCLE shift-add (multiply) or restoring-subtract (divide) steps.
module muldiv_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_out
);

    // Accumulator layout: multiply {product_hi, multiplier}, divide {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] stage [0:BITS_PER_CYCLE];

    assign stage[0] = acc_in;

    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            logic [XLEN:0] sum;
            logic [XLEN:0] trial;
            logic [XLEN:0] diff;
            logic [2*XLEN-1:0] mul_next;
            logic [2*XLEN-1:0] div_next;

            assign sum   = {1'b0, stage[gi][2*XLEN-1:XLEN]} + {1'b0, operand};
            // Remainder can reach 2^XLEN-2 before the shift, so the trial needs one extra bit.
            assign trial = stage[gi][2*XLEN-1:XLEN-1];
            assign diff  = trial - {1'b0, operand};

            assign mul_next = stage[gi][0] ? {sum, stage[gi][XLEN-1:1]}
                                           : {1'b0, stage[gi][2*XLEN-1:1]};
            assign div_next = diff[XLEN] ? {trial[XLEN-1:0], stage[gi][XLEN-2:0], 1'b0}
                                         : {diff[XLEN-1:0],  stage[gi][XLEN-2:0], 1'b1};

            assign stage[gi+1] = is_div ? div_next : mul_next;
        end
    endgenerate

    assign acc_out = stage[BITS_PER_CYCLE];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide with a sign-fix cycle.
module muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int ITER  = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    muldiv_state_t     state_reg;
    muldiv_op_t        op_reg;
    logic [XLEN-1:0]   operand_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic              neg_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   result_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              is_div, is_rem, div_zero, overflow, fast;
    logic [XLEN-1:0]   fast_result;
    logic              neg_next;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0]   operand_init;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_sel, div_fix, fix_result;

    // Operand decode at the accept edge.
    always_comb begin
        a_signed     = (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
        b_signed     = (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
        a_neg        = a_signed && src_a[XLEN-1];
        b_neg        = b_signed && src_b[XLEN-1];
        a_mag        = a_neg ? -src_a : src_a;
        b_mag        = b_neg ? -src_b : src_b;
        is_div       = op[2];
        is_rem       = op[2] && op[1];
        div_zero     = is_div && (src_b == '0);
        overflow     = ((op == DIV) || (op == REM)) &&
                       (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        fast         = div_zero || overflow;
        fast_result  = div_zero ? (is_rem ? src_a : '1) : (is_rem ? '0 : src_a);
        neg_next     = is_rem ? a_neg : (a_neg ^ b_neg);
        acc_init     = is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        operand_init = is_div ? b_mag : a_mag;
    end

    muldiv_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc_in  (acc_reg),
        .operand (operand_reg),
        .is_div  (op_reg[2]),
        .acc_out (acc_step)
    );

    always_comb begin
        prod_fix = neg_reg ? -acc_reg : acc_reg;
        div_sel  = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
        div_fix  = neg_reg ? -div_sel : div_sel;
        case (op_reg)
            MUL:                fix_result = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            default:            fix_result = div_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            op_reg        <= MUL;
            operand_reg   <= '0;
            acc_reg       <= '0;
            neg_reg       <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg       <= op;
                        in_ready_reg <= 1'b0;
                        if (fast) begin
                            result_reg    <= fast_result;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            acc_reg     <= acc_init;
                            operand_reg <= operand_init;
                            neg_reg     <= neg_next;
                            cnt_reg     <= '0;
                            state_reg   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(ITER - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    result_reg    <= fix_result;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    // A request presented alongside out_ready waits for the next IDLE cycle.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, fast paths, flush/reset abort and backpressure.
module tb_muldiv_unit;
    import rv_pkg::*;

    localparam int BPC  = 1;
    localparam int ITER = 32 / BPC;
    localparam int LAT  = ITER + 2;
    localparam int MID  = (ITER > 12) ? 10 : ITER / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    muldiv_op_t  op = MUL;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(
        .XLEN           (32),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request in IDLE and return just after its accept edge, with junk on the inputs.
    task automatic issue(input string tag, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        op = o;
        src_a = a;
        src_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = REMU;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    // Count cycles from the accept edge until out_valid, check result and latency, optionally consume.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat, input bit take);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk(tag, result, exp);
        $display("op %s result=0x%08h latency=%0d", tag, result, n);
        if (take) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic run(input string tag, input muldiv_op_t o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(tag, o, a, b);
        wait_done(tag, exp, lat, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        run("mul",    MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
        run("mulh",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, LAT);
        run("mulhsu", MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, LAT);
        run("mulhu",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
        run("div",    DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT);
        run("rem",    REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT);
        run("div_pn", DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
        run("rem_pn", REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         LAT);
        run("divu",   DIVU,   32'd100,        32'd7,         32'd14,        LAT);
        run("remu",   REMU,   32'd100,        32'd7,         32'd2,         LAT);

        run("divu_z", DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run("rem_z",  REM,    32'd5,          32'd0,         32'd5,         1);
        run("div_ov", DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ov", REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Backpressure: result held for 5 cycles while a new request waits.
        issue("bp", MUL, 32'd6, 32'd7);
        wait_done("bp", 32'd42, LAT, 1'b0);
        op = DIVU;
        src_a = 32'd20;
        src_b = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_result", result, 32'd42);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("bp_next", 32'd5, LAT, 1'b1);

        // Flush wins over a same-cycle accept.
        @(negedge clk);
        op = DIVU;
        src_a = 32'd5;
        src_b = 32'd0;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_accept_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_accept_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush mid-CALC.
        issue("flush_mid", DIVU, 32'd1000, 32'd7);
        repeat (MID) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_mid_out_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_mid_no_valid", {31'd0, seen}, 32'd0);

        // Reset mid-CALC also clears the held result.
        issue("reset_mid", DIVU, 32'd1000, 32'd7);
        repeat (MID) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_mid_result", result, 32'd0);
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("reset_mid_no_valid", {31'd0, seen}, 32'd0);

        run("divu_after", DIVU, 32'd9, 32'd3, 32'd3, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
